// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: loads a pattern into a scan chain, pulses one capture cycle, and unloads the response.
// Optional SCAN_CMP_EN macro adds a registered response != expected flag.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic                 scan_out,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] response,
  output logic                 mismatch
);
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);
  typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, UNLOAD, DONE} state_t;
  state_t state, state_nxt;
  logic [CHAIN_LEN-1:0] sreg, rsp, rsp_nxt;
  logic [CNT_W-1:0] cnt;
  logic last;
  assign last = cnt == LAST;
  // Truncating cast keeps CHAIN_LEN=1 free of special cases.
  assign rsp_nxt = CHAIN_LEN'({rsp, scan_out});
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? SHIFT : IDLE;
      SHIFT:   state_nxt = last ? CAPTURE : SHIFT;
      CAPTURE: state_nxt = UNLOAD;
      UNLOAD:  state_nxt = last ? DONE : UNLOAD;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    scan_en = state == SHIFT || state == UNLOAD;
    scan_in = state == SHIFT && sreg[CHAIN_LEN-1];
    busy    = state == SHIFT || state == CAPTURE || state == UNLOAD;
    done    = state == DONE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      sreg     <= '0;
      rsp      <= '0;
      cnt      <= '0;
      response <= '0;
    end else begin
      cnt <= (state == SHIFT || state == UNLOAD) && !last ? cnt + 1'b1 : '0;
      if (state == IDLE && start) sreg <= pattern;
      else if (state == SHIFT) sreg <= sreg << 1;
      if (state == UNLOAD) rsp <= rsp_nxt;
      if (state == UNLOAD && last) response <= rsp_nxt;
    end
`ifdef SCAN_CMP_EN
  always_ff @(posedge clk)
    if (rst) mismatch <= 1'b0;
    else if (state == UNLOAD && last) mismatch <= rsp_nxt != expected;
`else
  logic unused_expected;
  assign unused_expected = ^expected;
  assign mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: table-driven bench with a behavioural scan chain and a response scoreboard.
module tb_scan_chain_ctrl;
  localparam int N = 8;
`ifdef SCAN_CMP_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, hold = 1'b1;
  logic scan_out, scan_en, scan_in, busy, done, mismatch;
  logic [N-1:0] pattern = '0, expected = '0, dconst = '0, chain = '0, response;
  logic start1 = 1'b0, exp1 = 1'b0, c1 = 1'b0, en1, si1, busy1, done1, rsp1, mm1, pat1;
  int checks = 0, errors = 0;
  logic [N-1:0] sb[$];

  typedef struct {
    logic [7:0]  pat;
    logic        hold;
    logic [7:0]  dc;
    logic [7:0]  exp_cmp;
    logic [7:0]  rsp;
    logic        mm;
    logic [31:0] spulse;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;
  assign scan_out = chain[N-1];
  assign pat1 = 1'b1;
  always @(posedge clk) chain <= scan_en ? {chain[N-2:0], scan_in} : (hold ? chain : dconst);
  always @(posedge clk) c1 <= en1 ? si1 : ~c1;

  scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .expected(expected),
    .scan_out(scan_out), .scan_en(scan_en), .scan_in(scan_in), .busy(busy),
    .done(done), .response(response), .mismatch(mismatch));

  scan_chain_ctrl #(.CHAIN_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .pattern(pat1), .expected(exp1),
    .scan_out(c1), .scan_en(en1), .scan_in(si1), .busy(busy1),
    .done(done1), .response(rsp1), .mismatch(mm1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input logic [7:0] prev);
    logic [31:0] en_v, si_v, exp_en, exp_si;
    int busy_n, done_n, done_at;
    en_v = 0; si_v = 0; exp_en = 0; exp_si = 0; busy_n = 0; done_n = 0; done_at = 0;
    for (int k = 1; k <= 2*N+1; k++) if (k != N+1) exp_en[k] = 1'b1;
    for (int k = 1; k <= N; k++) exp_si[k] = v.pat[N-k];
    @(negedge clk);
    pattern = v.pat; hold = v.hold; dconst = v.dc; expected = v.exp_cmp; start = 1'b1;
    sb.push_back(v.rsp);
    for (int k = 1; k <= 2*N+4; k++) begin
      @(negedge clk);
      en_v[k] = scan_en;
      si_v[k] = scan_in;
      busy_n += int'(busy);
      if (k == 1) chk("rsp_hold", response, prev);
      if (done) begin
        done_n++;
        done_at = k;
        if (sb.size() > 0) chk("response", response, sb.pop_front());
        else chk("sb_underflow", 1, 0);
        chk("mismatch", mismatch, CMP ? v.mm : 1'b0);
      end
      start = v.spulse[k];
    end
    start = 1'b0;
    chk("done_at", done_at, 2*N+2);
    chk("done_count", done_n, 1);
    chk("busy_cycles", busy_n, 2*N+1);
    chk("scan_en_wave", en_v, exp_en);
    chk("scan_in_wave", si_v, exp_si);
    chk("rsp_after", response, v.rsp);
  endtask

  initial begin
    int at;
    logic [7:0] prev;
    vecs[0] = '{8'hA5, 1'b1, 8'h00, 8'hA5, 8'hA5, 1'b0, 32'h0};
    vecs[1] = '{8'hFF, 1'b0, 8'h3C, 8'h3C, 8'h3C, 1'b0, 32'h0};
    vecs[2] = '{8'hFF, 1'b0, 8'h3C, 8'h3D, 8'h3C, 1'b1, 32'h0};
    vecs[3] = '{8'h5A, 1'b1, 8'h00, 8'h00, 8'h5A, 1'b1, 32'h0004_0004};
    vecs[4] = '{8'h01, 1'b1, 8'h00, 8'h01, 8'h01, 1'b0, 32'h0};
    repeat (3) @(negedge clk);
    chk("reset_outputs", {scan_en, scan_in, busy, done, mismatch, response}, 0);
    chk("reset_outputs_n1", {en1, si1, busy1, done1, mm1, rsp1}, 0);
    rst = 1'b0;
    prev = 8'h00;
    foreach (vecs[i]) begin
      run(vecs[i], prev);
      prev = vecs[i].rsp;
    end
    @(negedge clk);
    pattern = 8'hC3; hold = 1'b1; start = 1'b1;
    sb.push_back(8'hC3);
    for (int k = 1; k <= 2*N+4 && !(k > N+4); k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == N+4) rst = 1'b1;
    end
    @(negedge clk);
    chk("rst_mid_unload", {scan_en, scan_in, busy, done, mismatch, response}, 0);
    rst = 1'b0;
    void'(sb.pop_front());
    run(vecs[0], 8'h00);
    @(negedge clk);
    start1 = 1'b1;
    at = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (done1) begin
        at = k;
        chk("n1_response", rsp1, 1'b0);
        chk("n1_mismatch", mm1, 1'b0);
      end
    end
    chk("n1_done_at", at, 4);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
